pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial bit-stream generator that drives the `1011` sequence-detector family, both Moore and Mealy, in overlapping and non-overlapping modes. It accepts a parallel frame of up to WIDTH bits and shifts it out MSB-first, one bit per valid strobe. Its serial_o/valid_o pair connects directly to a detector's input_i/valid_i. It is the stimulus and transmit end of the detector interface, with a load/ready handshake toward the controlling logic.

## Interface
- WIDTH, 16: maximum frame length in bits.
- GAP_W, 4: width of the inter-bit gap count.
- clk_i  input  1  clock; all logic on the rising edge.
- clr_i  input  1  synchronous, active-high reset.
- data_i  input  WIDTH  frame bits; bit len_i-1 is sent first, bit 0 last.
- len_i  input  $clog2(WIDTH+1)  frame length; legal range 1..WIDTH.
- gap_i  input  GAP_W  idle cycles inserted after every bit except the last.
- load_i  input  1  load request; accepted when load_i && ready_o.
- ready_o  output  1  block idle, can accept a load.
- serial_o  output  1  current serial bit; forced to 0 when valid_o=0.
- valid_o  output  1  serial_o carries a bit this cycle.
- last_o  output  1  high with the final bit of the frame.
- done_o  output  1  single-cycle pulse after a frame completes.

## Operation
- All outputs are registered.
- Reset value: ready_o=1, serial_o=0, valid_o=0, last_o=0, done_o=0, FSM in IDLE, counters 0.
- FSM states: IDLE, SEND, GAP.
- **IDLE**
  - ready_o=1.
  - On load_i with 1≤len_i≤WIDTH: capture data_i into the shift register, remaining-bit counter=len_i, gap reload=gap_i; go to SEND.
  - load_i with len_i=0 or len_i>WIDTH is ignored: no output, ready_o stays 1.
- **SEND**
  - valid_o=1, serial_o=shreg[len-1 pointer], ready_o=0; decrement remaining.
  - If this is the last bit: last_o=1, then go to IDLE with done_o=1 in the following cycle.
  - Else, if the gap reload is 0: stay in SEND.
  - Else: go to GAP with gap counter=gap reload.
- **GAP**
  - valid_o=0, serial_o=0.
  - Decrement the gap counter; at 1, return to SEND.
- No trailing gap after the last bit.
- data_i, len_i and gap_i are sampled only at load; changes mid-frame have no effect.
- load_i while ready_o=0 is dropped, not queued.
- clr_i mid-frame:
  - aborts the frame immediately, next cycle at the reset values;
  - no done_o, no last_o;
  - clr_i has priority over load_i in the same cycle.

## Timing
- Load accepted at edge N:
  - first bit valid in cycle N+1;
  - ready_o low from N+1.
- Frame of L bits with gap G occupies L + (L-1)·G cycles of non-IDLE.
- Cycle after last_o:
  - done_o=1, ready_o=1, valid_o=0;
  - a load in this cycle is accepted, giving one idle cycle minimum between frames.
- done_o is exactly one cycle wide.
- done_o and ready_o rising coincide.

## Configuration
- GAP_INSERT_EN defined:
  - gap_i is honoured;
  - GAP state and gap counter are present.
- GAP_INSERT_EN undefined:
  - gap_i is ignored (port kept, unused);
  - GAP state and counter are not synthesised;
  - bits are sent back-to-back, valid_o continuously high for L cycles.

## Structure
- Package pattern_pkg holds:
  - FSM state encoding (one-hot, 3 bits: ST_IDLE, ST_SEND, ST_GAP);
  - constant PATTERN_1011 = 4'b1011;
  - default WIDTH/GAP_W constants.
  - Shared with the detectors.
- One sub-module, pattern_tx_gap_ctr:
  - loadable down-counter;
  - outputs a "zero next" flag;
  - instantiated only under GAP_INSERT_EN.
- Shift register, bit counter and FSM live in pattern_tx.

## Test plan
- Reset: hold clr_i 2 cycles → ready_o=1, valid_o=0, serial_o=0, last_o=0, done_o=0.
- Basic frame: load data_i=16'h000B, len_i=4, gap_i=0 → serial_o 1,0,1,1 on 4 consecutive valid_o cycles; last_o on the 4th; done_o and ready_o the next cycle. A non-overlapping Moore detector on the output raises out once.
- Gap (GAP_INSERT_EN): len_i=4, data 1011, gap_i=2 → valid pattern 1,0,0,1,0,0,1,0,0,1 over 10 cycles. Without the macro: 4 contiguous valid cycles.
- Overlap stream: len_i=7, data 7'b1011011 → bits 1011011 MSB-first. An overlapping detector fires twice, a non-overlapping detector once.
- Illegal/blocked loads:
  - len_i=0 → no valid_o, ready_o stays 1.
  - load_i pulsed mid-frame → ignored; the current frame completes unchanged.
- Reset mid-frame: clr_i at the 3rd bit of a 16-bit frame → next cycle valid_o=0, ready_o=1, no done_o. A new load then sends the full frame from its MSB.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the 1011 pattern transmitter and the detector family:
// one-hot FSM encoding, the target pattern and default sizing.
package pattern_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_SEND = 3'b010,
      ST_GAP  = 3'b100
   } state_e;

   localparam logic [3:0] PATTERN_1011 = 4'b1011;
   localparam int         WIDTH_DEF    = 16;
   localparam int         GAP_W_DEF    = 4;

endpackage

// File: rtl/pattern_tx_if.sv
// Load/ready handshake plus serial output bundle of the pattern transmitter.
interface pattern_tx_if
   import pattern_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int GAP_W = GAP_W_DEF
) ();
   localparam int LEN_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] data_i;
   logic [LEN_W-1:0] len_i;
   logic [GAP_W-1:0] gap_i;
   logic             load_i;
   logic             ready_o;
   logic             serial_o;
   logic             valid_o;
   logic             last_o;
   logic             done_o;

   modport master (
      output data_i, len_i, gap_i, load_i,
      input  ready_o, serial_o, valid_o, last_o, done_o
   );

   modport slave (
      input  data_i, len_i, gap_i, load_i,
      output ready_o, serial_o, valid_o, last_o, done_o
   );
endinterface

// File: rtl/pattern_tx_gap_ctr.sv
// Loadable down-counter timing the idle cycles between serial bits;
// zero_nxt_o flags the final gap cycle so the FSM can return to SEND.
module pattern_tx_gap_ctr #(
   parameter int GAP_W = 4
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [GAP_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_nxt_o
);
   logic [GAP_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_nxt_o = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/pattern_tx.sv
// Parallel-to-serial frame transmitter, MSB-first, feeding the 1011 detectors.
// Define GAP_INSERT_EN to honour gap_i with idle cycles between bits.
module pattern_tx
   import pattern_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int GAP_W = GAP_W_DEF
) (
   input  logic        clk_i,
   input  logic        clr_i,
   pattern_tx_if.slave tx
);
   localparam int               LEN_W   = $clog2(WIDTH + 1);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_e           state_q, state_n;
   logic [WIDTH-1:0] shreg_q, shreg_n;
   logic [LEN_W-1:0] rem_q, rem_n;
   logic             ready_q, serial_q, valid_q, last_q, done_q;
   logic             ready_n, serial_n, valid_n, last_n, done_n;
   logic             load_ok;

   assign load_ok = tx.load_i && (tx.len_i != '0) && (tx.len_i <= LEN_W'(WIDTH));

`ifdef GAP_INSERT_EN
   logic [GAP_W-1:0] gap_q;
   logic             ctr_load, ctr_dec, ctr_zero_nxt;

   pattern_tx_gap_ctr #(.GAP_W(GAP_W)) u_gap_ctr (
      .clk_i      (clk_i),
      .clr_i      (clr_i),
      .load_i     (ctr_load),
      .load_val_i (gap_q),
      .dec_i      (ctr_dec),
      .zero_nxt_o (ctr_zero_nxt)
   );

   always_ff @(posedge clk_i) begin
      if ((state_q == ST_IDLE) && load_ok) gap_q <= tx.gap_i;
   end
`else
   logic [GAP_W-1:0] unused_gap;
   assign unused_gap = tx.gap_i;
`endif

   // State register: control and outputs reset, shift register does not
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q  <= ST_IDLE;
         rem_q    <= '0;
         ready_q  <= 1'b1;
         serial_q <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         rem_q    <= rem_n;
         ready_q  <= ready_n;
         serial_q <= serial_n;
         valid_q  <= valid_n;
         last_q   <= last_n;
         done_q   <= done_n;
      end
   end

   always_ff @(posedge clk_i) begin
      shreg_q <= shreg_n;
   end

   // Next state: the frame is left-aligned so the outgoing bit is always the MSB
   always_comb begin
      state_n = state_q;
      shreg_n = shreg_q;
      rem_n   = rem_q;
`ifdef GAP_INSERT_EN
      ctr_load = 1'b0;
      ctr_dec  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (load_ok) begin
               state_n = ST_SEND;
               shreg_n = tx.data_i << (WIDTH - int'(tx.len_i));
               rem_n   = tx.len_i;
            end
         end
         ST_SEND: begin
            shreg_n = shreg_q << 1;
            rem_n   = rem_q - 1'b1;
            if (rem_q == LEN_ONE) begin
               state_n = ST_IDLE;
            end
`ifdef GAP_INSERT_EN
            else if (gap_q != '0) begin
               state_n  = ST_GAP;
               ctr_load = 1'b1;
            end
`endif
         end
`ifdef GAP_INSERT_EN
         ST_GAP: begin
            ctr_dec = 1'b1;
            if (ctr_zero_nxt) state_n = ST_SEND;
         end
`endif
         default: state_n = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state and registered
   always_comb begin
      ready_n  = (state_n == ST_IDLE);
      valid_n  = (state_n == ST_SEND);
      serial_n = valid_n & shreg_n[WIDTH-1];
      last_n   = valid_n && (rem_n == LEN_ONE);
      done_n   = (state_q == ST_SEND) && (rem_q == LEN_ONE);
   end

   assign tx.ready_o  = ready_q;
   assign tx.serial_o = serial_q;
   assign tx.valid_o  = valid_q;
   assign tx.last_o   = last_q;
   assign tx.done_o   = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: frames expand into expected bit records,
// a negedge monitor pops one record per valid_o cycle and checks it.
module tb_pattern_tx;
   import pattern_pkg::*;

   localparam int WIDTH = 16;
   localparam int GAP_W = 4;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   pattern_tx_if #(.WIDTH(WIDTH), .GAP_W(GAP_W)) tx ();

   pattern_tx #(.WIDTH(WIDTH), .GAP_W(GAP_W)) dut (
      .clk_i (clk),
      .clr_i (clr),
      .tx    (tx)
   );

   typedef struct {
      bit b;
      bit last;
      bit first;
      int gap;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   gapc   = 0;
   bit   exp_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int eff_gap(input int g);
`ifdef GAP_INSERT_EN
      return g;
`else
      return 0 * g;
`endif
   endfunction

   // Reference: bits leave MSB-first from position len-1 down to 0
   task automatic push_frame(input logic [15:0] d, input int len, input int g);
      for (int i = len - 1; i >= 0; i--) begin
         exp_t e;
         e.b     = d[i];
         e.last  = (i == 0);
         e.first = (i == len - 1);
         e.gap   = eff_gap(g);
         q.push_back(e);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the sampling edge
   task automatic load(input logic [15:0] d, input int len, input int g);
      tx.data_i = d;
      tx.len_i  = 5'(len);
      tx.gap_i  = 4'(g);
      tx.load_i = 1'b1;
      if (len >= 1 && len <= WIDTH) push_frame(d, len, g);
      @(posedge clk);
      #1;
      tx.load_i = 1'b0;
      tx.data_i = 16'($urandom);
      tx.len_i  = 5'($urandom);
      tx.gap_i  = 4'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || tx.ready_o !== 1'b1) && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("idle_timeout", 32'(n >= 1000), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit   nxt_done;
      nxt_done = 1'b0;
      if (tx.valid_o === 1'b1) begin
         if (q.size() == 0) begin
            chk("spurious_valid", 1, 0);
         end else begin
            e = q.pop_front();
            chk("serial", tx.serial_o, e.b);
            chk("last", tx.last_o, e.last);
            chk("ready_busy", tx.ready_o, 0);
            if (!e.first) chk("gap_len", gapc, e.gap);
            nxt_done = e.last;
         end
         gapc = 0;
      end else if (tx.valid_o === 1'b0) begin
         gapc++;
         chk("serial_idle", tx.serial_o, 0);
      end
      if (exp_done || tx.done_o === 1'b1) begin
         chk("done", tx.done_o, exp_done);
         if (exp_done) chk("ready_at_done", tx.ready_o, 1);
      end
      exp_done = nxt_done;
   end

   initial begin
      logic [15:0] d;
      int          len, g, n;
      tx.load_i = 1'b0;
      tx.data_i = '0;
      tx.len_i  = '0;
      tx.gap_i  = '0;
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", tx.ready_o, 1);
      chk("rst_valid", tx.valid_o, 0);
      chk("rst_serial", tx.serial_o, 0);
      chk("rst_last", tx.last_o, 0);
      chk("rst_done", tx.done_o, 0);
      clr = 1'b0;
      @(posedge clk);
      #1;

      load(16'h000B, 4, 0);
      chk("ready_low_after_load", tx.ready_o, 0);
      wait_idle();
      load(16'h000B, 4, 2);
      wait_idle();
      load(16'h005B, 7, 1);
      wait_idle();

      // Illegal lengths never start a frame
      for (int k = 0; k < 2; k++) begin
         load(16'hFFFF, (k == 0) ? 0 : 17, 0);
         repeat (3) begin
            chk("illegal_ready", tx.ready_o, 1);
            chk("illegal_valid", tx.valid_o, 0);
            @(posedge clk);
            #1;
         end
      end

      // Load pulsed mid-frame is dropped
      load(16'hA5C3, 16, 1);
      repeat (3) @(posedge clk);
      #1;
      tx.data_i = 16'hFFFF;
      tx.len_i  = 5'd5;
      tx.load_i = 1'b1;
      @(posedge clk);
      #1;
      tx.load_i = 1'b0;
      wait_idle();

      // Reset during the third bit, with a competing load
      d = 16'($urandom);
      g = $urandom_range(0, 2);
      load(d, 16, g);
      n = 0;
      while (!(tx.valid_o === 1'b1 && q.size() == 14) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("third_bit_timeout", 32'(n >= 500), 0);
      clr       = 1'b1;
      tx.load_i = 1'b1;
      tx.data_i = 16'hFFFF;
      tx.len_i  = 5'd16;
      @(posedge clk);
      #1;
      clr       = 1'b0;
      tx.load_i = 1'b0;
      q.delete();
      chk("abort_valid", tx.valid_o, 0);
      chk("abort_ready", tx.ready_o, 1);
      chk("abort_done", tx.done_o, 0);
      chk("abort_last", tx.last_o, 0);
      @(posedge clk);
      #1;
      chk("abort_no_frame", tx.valid_o, 0);
      load(d, 16, g);
      wait_idle();

      repeat (25) begin
         d   = 16'($urandom);
         len = $urandom_range(1, 16);
         g   = $urandom_range(0, 3);
         load(d, len, g);
         wait_idle();
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
